// File: rtl/ps2_key_state_tracker.sv
// ps2_key_state_tracker
// Deserialises the PS/2 keyboard stream into scan-code bytes, decodes the
// make / break / extended prefixes and keeps a bitmap of held piano keys.
//
// Optional build macro: PS2_PARITY_CHECK_EN
//   defined     -> frames with bad odd parity or a low stop bit are dropped
//                  and reported on frame_err.
//   not defined -> parity and stop bits are ignored; frame_err only reports
//                  a mid-frame timeout.
//
// Decoder FSM
//   state        | meaning
//   ST_IDLE      | waiting for a make code or a prefix byte
//   ST_BREAK     | F0 seen, next mapped byte clears its key bit
//   ST_EXT       | E0 seen, extended key (never mapped)
//   ST_EXT_BREAK | E0 F0 seen, swallow the next byte
module ps2_key_state_tracker #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int NUM_KEYS       = 16
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic                PS2_CLK,
   input  logic                PS2_DAT,
   output logic [NUM_KEYS-1:0] inputStateStorage,
   output logic [7:0]          scancode,
   output logic                scancode_valid,
   output logic                frame_err
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BREAK,
      ST_EXT,
      ST_EXT_BREAK
   } dec_state_t;

   logic            clk_s1, clk_s2, clk_s3;
   logic            dat_s1, dat_s2;
   logic            ps2_fall;

   logic [3:0]      bit_cnt;
   logic [9:0]      shift_reg;
   logic [TO_W-1:0] to_cnt;
   logic            frame_ok;

   dec_state_t      dec_state;
   logic            key_hit;
   logic [3:0]      key_idx;
   logic            key_set;
   logic            key_clr;
   logic [NUM_KEYS-1:0] key_mask;

   // Two-flop synchronisers plus a history flop on the clock for edge detect
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_s3 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= PS2_CLK;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= PS2_DAT;
         dat_s2 <= dat_s1;
      end
   end

   assign ps2_fall = clk_s3 & ~clk_s2;

   // Frame acceptance; shift_reg holds start, data[7:0], parity in bits 0..9
   // and the stop bit is still on dat_s2 when this is evaluated.
`ifdef PS2_PARITY_CHECK_EN
   always_comb begin
      frame_ok = ~shift_reg[0] & (^shift_reg[9:1]) & dat_s2;
   end
`else
   always_comb begin
      frame_ok = ~shift_reg[0];
   end
`endif

   // Receiver: bit counter, shift register, inactivity timer and pulses
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         bit_cnt        <= 4'd0;
         shift_reg      <= 10'd0;
         to_cnt         <= '0;
         scancode       <= 8'h00;
         scancode_valid <= 1'b0;
         frame_err      <= 1'b0;
      end else begin
         scancode_valid <= 1'b0;
         frame_err      <= 1'b0;
         if (ps2_fall) begin
            to_cnt <= TO_W'(TIMEOUT_CYCLES);
            if (bit_cnt == 4'd0) begin
               // A high start bit is noise: stay aligned on bit 0
               if (!dat_s2) begin
                  shift_reg <= {dat_s2, shift_reg[9:1]};
                  bit_cnt   <= 4'd1;
               end
            end else if (bit_cnt == 4'd10) begin
               bit_cnt <= 4'd0;
               if (frame_ok) begin
                  scancode       <= shift_reg[8:1];
                  scancode_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
            end else begin
               shift_reg <= {dat_s2, shift_reg[9:1]};
               bit_cnt   <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != 4'd0) begin
            // Down-counter reloaded on every edge; terminal count abandons frame
            if (to_cnt <= TO_W'(1)) begin
               bit_cnt   <= 4'd0;
               frame_err <= 1'b1;
               to_cnt    <= '0;
            end else begin
               to_cnt <= to_cnt - TO_W'(1);
            end
         end
      end
   end

   // Scan code to key index lookup
   always_comb begin
      key_hit = 1'b1;
      key_idx = 4'd0;
      case (scancode)
         8'h29:   key_idx = 4'd0;
         8'h5D:   key_idx = 4'd1;
         8'h1C:   key_idx = 4'd2;
         8'h1B:   key_idx = 4'd3;
         8'h23:   key_idx = 4'd4;
         8'h2B:   key_idx = 4'd5;
         8'h34:   key_idx = 4'd6;
         8'h33:   key_idx = 4'd7;
         8'h3B:   key_idx = 4'd8;
         8'h42:   key_idx = 4'd9;
         8'h4B:   key_idx = 4'd10;
         8'h1D:   key_idx = 4'd11;
         8'h24:   key_idx = 4'd12;
         8'h2C:   key_idx = 4'd13;
         8'h35:   key_idx = 4'd14;
         8'h3C:   key_idx = 4'd15;
         default: key_hit = 1'b0;
      endcase
   end

   // Decoder FSM; emits a registered set/clear command for the bitmap
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         dec_state <= ST_IDLE;
         key_set   <= 1'b0;
         key_clr   <= 1'b0;
         key_mask  <= '0;
      end else begin
         key_set <= 1'b0;
         key_clr <= 1'b0;
         if (scancode_valid) begin
            key_mask <= NUM_KEYS'(1) << key_idx;
            case (dec_state)
               ST_IDLE: begin
                  if (scancode == 8'hF0) begin
                     dec_state <= ST_BREAK;
                  end else if (scancode == 8'hE0) begin
                     dec_state <= ST_EXT;
                  end else if (key_hit) begin
                     key_set <= 1'b1;
                  end
               end
               ST_BREAK: begin
                  key_clr   <= key_hit;
                  dec_state <= ST_IDLE;
               end
               ST_EXT: begin
                  dec_state <= (scancode == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
               end
               ST_EXT_BREAK: begin
                  dec_state <= ST_IDLE;
               end
               default: dec_state <= ST_IDLE;
            endcase
         end
      end
   end

   // Held-key bitmap; repeated makes and stray breaks are naturally no-ops
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         inputStateStorage <= '0;
      end else if (key_set) begin
         inputStateStorage <= inputStateStorage | key_mask;
      end else if (key_clr) begin
         inputStateStorage <= inputStateStorage & ~key_mask;
      end
   end

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// Bench for ps2_key_state_tracker: scoreboard of expected scan codes popped
// on each scancode_valid, plus bitmap, latency and pulse checks.
module tb_ps2_key_state_tracker;

   localparam int TO_CYC   = 300;
   localparam int NUM_KEYS = 16;

   logic                CLOCK_50;
   logic                resetn;
   logic                PS2_CLK;
   logic                PS2_DAT;
   logic [NUM_KEYS-1:0] inputStateStorage;
   logic [7:0]          scancode;
   logic                scancode_valid;
   logic                frame_err;

   ps2_key_state_tracker #(
      .TIMEOUT_CYCLES (TO_CYC),
      .NUM_KEYS       (NUM_KEYS)
   ) dut (
      .CLOCK_50          (CLOCK_50),
      .resetn            (resetn),
      .PS2_CLK           (PS2_CLK),
      .PS2_DAT           (PS2_DAT),
      .inputStateStorage (inputStateStorage),
      .scancode          (scancode),
      .scancode_valid    (scancode_valid),
      .frame_err         (frame_err)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] exp_q[$];
   int exp_valid     = 0;
   int exp_err       = 0;
   int valid_cnt     = 0;
   int err_cnt       = 0;
   int spurious      = 0;
   int long_pulse    = 0;
   int err_cyc       = 0;
   int bm_change_cyc = 0;
   int last_fall_cyc = 0;
   logic valid_prev  = 1'b0;
   logic err_prev    = 1'b0;
   logic [NUM_KEYS-1:0] bm_prev = '0;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   // Output monitor: pops the scoreboard on every accepted byte
   always @(negedge CLOCK_50) begin
      if (resetn) begin
         if (scancode_valid) begin
            valid_cnt++;
            if (valid_prev) long_pulse++;
            if (exp_q.size() > 0) chk_val("scancode", {24'd0, scancode}, {24'd0, exp_q.pop_front()});
            else spurious++;
         end
         if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
            if (err_prev) long_pulse++;
         end
         if (inputStateStorage != bm_prev) bm_change_cyc = cyc;
      end
      valid_prev = scancode_valid;
      err_prev   = frame_err;
      bm_prev    = inputStateStorage;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] b, input bit flip_par, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         PS2_DAT = fr[i];
         wait_clk(5);
         PS2_CLK = 1'b0;
         last_fall_cyc = cyc;
         wait_clk(10);
         PS2_CLK = 1'b1;
         wait_clk(5);
      end
      PS2_DAT = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit flip_par);
`ifdef PS2_PARITY_CHECK_EN
      if (flip_par) begin
         exp_err++;
      end else begin
         exp_q.push_back(b);
         exp_valid++;
      end
`else
      exp_q.push_back(b);
      exp_valid++;
`endif
      send_bits(b, flip_par, 11);
      wait_clk(6);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      resetn  = 1'b0;
      wait_clk(3);
      chk_val("reset_bitmap", {16'd0, inputStateStorage}, 32'h0);
      chk_val("reset_scancode", {24'd0, scancode}, 32'h0);
      resetn = 1'b1;
      wait_clk(TO_CYC + 50);
      chk_val("idle_bitmap", {16'd0, inputStateStorage}, 32'h0);
      chk_val("idle_valid_cnt", valid_cnt, 0);
      chk_val("idle_err_cnt", err_cnt, 0);

      // make/break of spacebar with latency check on the make
      send_frame(8'h29, 1'b0);
      chk_val("make_latency", bm_change_cyc - last_fall_cyc, 5);
      chk_val("bm_29", {16'd0, inputStateStorage}, 32'h0001);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h29, 1'b0);
      chk_val("bm_brk29", {16'd0, inputStateStorage}, 32'h0000);
      chk_val("valid_cnt_3", valid_cnt, 3);

      // two keys held, typematic repeat, then release of one
      send_frame(8'h1C, 1'b0);
      chk_val("bm_1c", {16'd0, inputStateStorage}, 32'h0004);
      send_frame(8'h1C, 1'b0);
      chk_val("bm_1c_rep", {16'd0, inputStateStorage}, 32'h0004);
      send_frame(8'h5D, 1'b0);
      chk_val("bm_5d", {16'd0, inputStateStorage}, 32'h0006);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      chk_val("bm_brk1c", {16'd0, inputStateStorage}, 32'h0002);

      // extended make and break leave bitmap alone and return to idle
      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      chk_val("bm_ext", {16'd0, inputStateStorage}, 32'h0002);
      send_frame(8'h29, 1'b0);
      chk_val("bm_after_ext", {16'd0, inputStateStorage}, 32'h0003);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h29, 1'b0);
      chk_val("bm_brk29_b", {16'd0, inputStateStorage}, 32'h0002);

      // flipped parity on a spacebar make
      e0 = err_cnt;
      send_frame(8'h29, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      chk_val("bad_par_err", err_cnt - e0, 1);
      chk_val("bad_par_bm", {16'd0, inputStateStorage}, 32'h0002);
`else
      chk_val("bad_par_err", err_cnt - e0, 0);
      chk_val("bad_par_bm", {16'd0, inputStateStorage}, 32'h0003);
`endif
      send_frame(8'hF0, 1'b0);
      send_frame(8'h29, 1'b0);
      chk_val("bm_after_par", {16'd0, inputStateStorage}, 32'h0002);

      // truncated frame times out; next full frame is received normally
      e0 = err_cnt;
      exp_err++;
      send_bits(8'hAA, 1'b0, 5);
      for (int i = 0; i < TO_CYC + 50; i++) begin
         if (err_cnt != e0) break;
         wait_clk(1);
      end
      chk_val("timeout_err", err_cnt - e0, 1);
      chk_val("timeout_latency", err_cyc - last_fall_cyc, TO_CYC + 3);
      send_frame(8'h1B, 1'b0);
      chk_val("bm_1b", {16'd0, inputStateStorage}, 32'h000A);

      // asynchronous reset in the middle of a frame
      send_bits(8'h1C, 1'b0, 5);
      resetn = 1'b0;
      #1;
      chk_val("rst_bitmap", {16'd0, inputStateStorage}, 32'h0);
      chk_val("rst_scancode", {24'd0, scancode}, 32'h0);
      chk_val("rst_pulses", {30'd0, scancode_valid, frame_err}, 32'h0);
      wait_clk(2);
      resetn = 1'b1;
      e0 = err_cnt;
      wait_clk(TO_CYC + 50);
      chk_val("rst_no_timeout", err_cnt - e0, 0);
      send_frame(8'h29, 1'b0);
      chk_val("bm_post_rst", {16'd0, inputStateStorage}, 32'h0001);

      wait_clk(10);
      chk_val("sb_empty", exp_q.size(), 0);
      chk_val("spurious_valid", spurious, 0);
      chk_val("pulse_width", long_pulse, 0);
      chk_val("total_valid", valid_cnt, exp_valid);
      chk_val("total_err", err_cnt, exp_err);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
